cmd_uart_host: RTL and testbench

Host-side initiator for the configuration UART link. It serialises a 24-bit configuration command into three UART bytes, high byte first, on `TX_C`. It then collects the two-byte response on `RX_C` and presents it as a 16-bit word. It sits at the opposite end of the wire from the configuration receiver and is used in the test-harness/host model and in any on-chip master driving a remote config port. Byte-level serialisation is done by the existing UART transceiver; this block owns sequencing, response assembly and timeout.

---
 rtl/cmd_uart_host.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_cmd_uart_host.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_host.sv
// Host-side configuration link initiator: sends a 24-bit command as three UART bytes
// (high byte first) and assembles the two-byte reply, with a response timeout.

module cmd_uart_xcvr #(
    parameter int BAUD_DIV = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_tx,
    input  logic       i_rx,
    output logic       o_rdy,
    output logic [7:0] o_rx_data,
    input  logic       i_clr_rdy
);
    localparam int BW = $clog2(BAUD_DIV + 1);
    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] C_BAUD_HALF = BW'(BAUD_DIV / 2);

    logic          r_tx_busy;
    logic [9:0]    r_tx_shift;
    logic [BW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;
    logic          r_tx_done;

    // Frame is {stop, data, start}; bit 0 is always what is on the wire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '1;
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (i_trmt) begin
                r_tx_busy  <= 1'b1;
                r_tx_shift <= {1'b1, i_tx_data, 1'b0};
                r_tx_baud  <= '0;
                r_tx_bits  <= '0;
            end else if (r_tx_busy) begin
                if (r_tx_baud == C_BAUD_LAST) begin
                    r_tx_baud  <= '0;
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                    if (r_tx_bits == 4'd9) begin
                        r_tx_busy <= 1'b0;
                        r_tx_done <= 1'b1;
                    end else begin
                        r_tx_bits <= r_tx_bits + 4'd1;
                    end
                end else begin
                    r_tx_baud <= r_tx_baud + 1'b1;
                end
            end
        end
    end

    assign o_tx      = r_tx_shift[0];
    assign o_tx_done = r_tx_done;

    logic [1:0]    r_rx_sync;
    logic          r_rx_busy;
    logic [BW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bits;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rdy;
    logic          w_rx;

    assign w_rx = r_rx_sync[1];

    // Samples near mid-bit: index 0 is the start bit, 1..8 data, 9 the stop bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rdy      <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], i_rx};
            if (i_clr_rdy) begin
                r_rdy <= 1'b0;
            end
            if (!r_rx_busy) begin
                if (!w_rx) begin
                    r_rx_busy <= 1'b1;
                    r_rx_baud <= C_BAUD_HALF;
                    r_rx_bits <= '0;
                end
            end else if (r_rx_baud == '0) begin
                r_rx_baud <= C_BAUD_LAST;
                if (r_rx_bits == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    r_rx_data <= r_rx_shift;
                    r_rdy     <= 1'b1;
                end else begin
                    if (r_rx_bits != 4'd0) begin
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                    end
                    r_rx_bits <= r_rx_bits + 4'd1;
                end
            end else begin
                r_rx_baud <= r_rx_baud - 1'b1;
            end
        end
    end

    assign o_rdy     = r_rdy;
    assign o_rx_data = r_rx_data;
endmodule

module cmd_uart_host #(
    parameter int TIMEOUT  = 2_000_000,
    parameter int BAUD_DIV = 434
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_snd_cmd,
    input  logic [23:0] i_cmd,
    output logic        o_tx_c,
    input  logic        i_rx_c,
    output logic        o_busy,
    output logic        o_cmd_sent,
    output logic        o_resp_rdy,
    output logic [15:0] o_resp,
    output logic        o_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_EXPIRE = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_TXH, S_TXM, S_TXL, S_RXH, S_RXL} state_t;

    state_t        r_state, w_state_next;
    logic [23:0]   r_cmd_q;
    logic [15:0]   r_resp;
    logic          r_resp_rdy;
    logic          r_timeout;
    logic          r_cmd_sent;
    logic          r_trmt;
    logic [7:0]    r_tx_data;
    logic          r_clr_rdy;
    logic [CW-1:0] r_cnt;

    logic       w_tx_done;
    logic       w_rdy;
    logic [7:0] w_rx_data;
    logic       w_rdy_ok;
    logic       w_expire;
    logic       w_accept;
    logic       w_trmt;
    logic [7:0] w_tx_byte;
    logic       w_cmd_sent;
    logic       w_clr_rdy;
    logic       w_cap_hi;
    logic       w_cap_lo;
    logic       w_set_timeout;
    logic       w_cnt_clr;

    cmd_uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .i_clk     (i_clk),
        .i_rst_n   (~i_rst),
        .i_trmt    (r_trmt),
        .i_tx_data (r_tx_data),
        .o_tx_done (w_tx_done),
        .o_tx      (o_tx_c),
        .i_rx      (i_rx_c),
        .o_rdy     (w_rdy),
        .o_rx_data (w_rx_data),
        .i_clr_rdy (r_clr_rdy)
    );

    // rdy is still high while our clr_rdy is in flight; don't consume it twice.
    assign w_rdy_ok = w_rdy & ~r_clr_rdy;
    assign w_expire = (r_cnt >= C_EXPIRE);

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_trmt        = 1'b0;
        w_tx_byte     = 8'h00;
        w_cmd_sent    = 1'b0;
        w_clr_rdy     = 1'b0;
        w_cap_hi      = 1'b0;
        w_cap_lo      = 1'b0;
        w_set_timeout = 1'b0;
        w_cnt_clr     = 1'b0;
        case (r_state)
            S_IDLE: if (i_snd_cmd) begin
                w_accept     = 1'b1;
                w_clr_rdy    = 1'b1;
                w_trmt       = 1'b1;
                w_tx_byte    = i_cmd[23:16];
                w_state_next = S_TXH;
            end
            S_TXH: if (w_tx_done) begin
                w_trmt       = 1'b1;
                w_tx_byte    = r_cmd_q[15:8];
                w_state_next = S_TXM;
            end
            S_TXM: if (w_tx_done) begin
                w_trmt       = 1'b1;
                w_tx_byte    = r_cmd_q[7:0];
                w_state_next = S_TXL;
            end
            S_TXL: if (w_tx_done) begin
                w_cmd_sent   = 1'b1;
                w_cnt_clr    = 1'b1;
                w_state_next = S_RXH;
            end
            S_RXH: if (w_rdy_ok) begin
                w_cap_hi     = 1'b1;
                w_clr_rdy    = 1'b1;
                w_state_next = S_RXL;
            end else if (w_expire) begin
                w_set_timeout = 1'b1;
                w_state_next  = S_IDLE;
            end
            S_RXL: if (w_rdy_ok) begin
                w_cap_lo     = 1'b1;
                w_clr_rdy    = 1'b1;
                w_state_next = S_IDLE;
            end else if (w_expire) begin
                w_set_timeout = 1'b1;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cmd_q    <= '0;
            r_resp     <= '0;
            r_resp_rdy <= 1'b0;
            r_timeout  <= 1'b0;
            r_cmd_sent <= 1'b0;
            r_trmt     <= 1'b0;
            r_tx_data  <= '0;
            r_clr_rdy  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_trmt     <= w_trmt;
            r_cmd_sent <= w_cmd_sent;
            r_clr_rdy  <= w_clr_rdy;
            if (w_trmt) begin
                r_tx_data <= w_tx_byte;
            end
            if (w_accept) begin
                r_cmd_q    <= i_cmd;
                r_resp_rdy <= 1'b0;
                r_timeout  <= 1'b0;
            end
            if (w_cap_hi) begin
                r_resp[15:8] <= w_rx_data;
            end
            if (w_cap_lo) begin
                r_resp[7:0] <= w_rx_data;
                r_resp_rdy  <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if ((r_state == S_RXH || r_state == S_RXL) && r_cnt != {CW{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_cmd_sent = r_cmd_sent;
    assign o_resp_rdy = r_resp_rdy;
    assign o_resp     = r_resp;
    assign o_timeout  = r_timeout;
endmodule

// File: tb/tb_cmd_uart_host.sv
// Bench for cmd_uart_host: a wire-level remote model decodes TX bytes and drives replies.

module tb_cmd_uart_host;
    localparam int BAUD = 8;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [23:0] cmd = '0;
    logic        rx_c = 1'b1;
    logic        tx_c;
    logic        busy, cmd_sent, resp_rdy, timeout_f;
    logic [15:0] resp;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sent = 0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    cmd_uart_host #(.TIMEOUT(TMO), .BAUD_DIV(BAUD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_snd_cmd  (snd_cmd),
        .i_cmd      (cmd),
        .o_tx_c     (tx_c),
        .i_rx_c     (rx_c),
        .o_busy     (busy),
        .o_cmd_sent (cmd_sent),
        .o_resp_rdy (resp_rdy),
        .o_resp     (resp),
        .o_timeout  (timeout_f)
    );

    // Remote receiver: decode 8N1 frames from the wire into a byte queue.
    always begin
        logic [7:0] b;
        @(negedge tx_c);
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = tx_c;
        end
        repeat (BAUD) @(negedge clk);
        tx_q.push_back(b);
    end

    always @(negedge clk) if (cmd_sent === 1'b1) n_sent++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) rx_c = frame[i];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    // which: 0 cmd_sent, 1 resp_rdy, 2 timeout, 3 first TX byte decoded
    task automatic wait_ev(input int which, input int budget, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0: hit = (cmd_sent === 1'b1);
                1: hit = (resp_rdy === 1'b1);
                2: hit = (timeout_f === 1'b1);
                default: hit = (tx_q.size() >= 1);
            endcase
        end
        chk($sformatf("wait_ev%0d", which), {31'd0, hit}, 32'd1);
    endtask

    task automatic start_cmd(input logic [23:0] c);
        tx_q.delete();
        @(negedge clk);
        snd_cmd = 1'b1;
        cmd = c;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = $urandom;
    endtask

    task automatic check_tx(input logic [23:0] c);
        chk("tx_count", tx_q.size(), 3);
        if (tx_q.size() == 3) begin
            chk("tx_byte_h", {24'd0, tx_q[0]}, {24'd0, c[23:16]});
            chk("tx_byte_m", {24'd0, tx_q[1]}, {24'd0, c[15:8]});
            chk("tx_byte_l", {24'd0, tx_q[2]}, {24'd0, c[7:0]});
        end
    endtask

    task automatic finish_txn(input logic [23:0] c, input logic [7:0] r0, input logic [7:0] r1);
        int n;
        int sent0;
        sent0 = n_sent;
        wait_ev(0, 2000, n);
        check_tx(c);
        send_byte(r0);
        send_byte(r1);
        wait_ev(1, 2000, n);
        chk("resp", {16'd0, resp}, {16'd0, r0, r1});
        chk("busy_done", {31'd0, busy}, 0);
        chk("timeout_clr", {31'd0, timeout_f}, 0);
        chk("cmd_sent_once", n_sent - sent0, 1);
        $display("txn cmd=%06h resp=%04h", c, resp);
    endtask

    initial begin
        int n;
        logic [23:0] c;
        logic [7:0] r0, r1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_resp", {16'd0, resp}, 0);
        chk("rst_tx", {31'd0, tx_c}, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic transaction
        start_cmd(24'hA53C0F);
        chk("busy_rise", {31'd0, busy}, 1);
        finish_txn(24'hA53C0F, 8'h12, 8'h34);
        chk("resp_rdy_set", {31'd0, resp_rdy}, 1);

        // Random transactions
        for (int k = 0; k < 4; k++) begin
            c  = 24'($urandom);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            start_cmd(c);
            finish_txn(c, r0, r1);
        end

        // Back-to-back: request on the cycle resp_rdy rises
        c = 24'($urandom);
        tx_q.delete();
        snd_cmd = 1'b1;
        cmd = c;
        @(negedge clk);
        snd_cmd = 1'b0;
        chk("b2b_resp_rdy_clr", {31'd0, resp_rdy}, 0);
        chk("b2b_busy", {31'd0, busy}, 1);
        finish_txn(c, 8'hA0, 8'h0B);

        // Ignored request during the middle byte
        start_cmd(24'h010203);
        wait_ev(3, 500, n);
        repeat (3 * BAUD) @(negedge clk);
        snd_cmd = 1'b1;
        cmd = 24'hFFFFFF;
        @(negedge clk);
        snd_cmd = 1'b0;
        finish_txn(24'h010203, 8'h5A, 8'hC3);
        chk("cmd_q_kept", {8'd0, dut.r_cmd_q}, {8'd0, 24'h010203});
        chk("ign_tx_count", tx_q.size(), 3);

        // Timeout with silent line
        start_cmd(24'h112233);
        wait_ev(0, 2000, n);
        check_tx(24'h112233);
        wait_ev(2, TMO + 100, n);
        chk("timeout_cycles", n, TMO);
        chk("timeout_resp_rdy", {31'd0, resp_rdy}, 0);
        chk("timeout_idle", {31'd0, busy}, 0);
        $display("txn cmd=112233 timeout after %0d cycles", n);
        start_cmd(24'h445566);
        chk("timeout_cleared", {31'd0, timeout_f}, 0);
        finish_txn(24'h445566, 8'h9E, 8'h21);

        // Partial response
        start_cmd(24'h778899);
        wait_ev(0, 2000, n);
        send_byte(8'h77);
        wait_ev(2, TMO + 100, n);
        chk("partial_timeout", {31'd0, timeout_f}, 1);
        chk("partial_resp_hi", {24'd0, resp[15:8]}, {24'd0, 8'h77});
        chk("partial_resp_rdy", {31'd0, resp_rdy}, 0);
        $display("txn cmd=778899 partial resp_hi=%02h", resp[15:8]);

        // Reset during the second TX byte
        start_cmd(24'h5A5A5A);
        wait_ev(3, 500, n);
        repeat (3 * BAUD) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_cmd_sent", {31'd0, cmd_sent}, 0);
        chk("mid_rst_resp_rdy", {31'd0, resp_rdy}, 0);
        chk("mid_rst_resp", {16'd0, resp}, 0);
        chk("mid_rst_timeout", {31'd0, timeout_f}, 0);
        chk("mid_rst_tx", {31'd0, tx_c}, 1);
        $display("reset mid-byte applied");
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * BAUD) @(negedge clk);
        start_cmd(24'h0A0B0C);
        finish_txn(24'h0A0B0C, 8'h3D, 8'hE4);

        // Stale byte received while idle must be flushed
        send_byte(8'hEE);
        repeat (20) @(negedge clk);
        start_cmd(24'hC0FFEE);
        finish_txn(24'hC0FFEE, 8'h56, 8'h78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
